sram_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one SRAM controller (15-bit word address, 16-bit data) between two requesters, e.g. CPU port and DMA port.
It accepts one request at a time, issues a single-cycle read/write request to the controller, and waits for its completion pulse.
It then returns a registered response to the granted port.
A watchdog bounds each transaction.

---
 rtl/sram_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Two-port round-robin arbiter in front of a single SRAM controller.
//   One transaction is in flight at a time: IDLE arbitrates and latches the
//   winning request, ISSUE drives a one-cycle read or write strobe, WAIT
//   waits for the controller completion pulse under a watchdog, and RESP
//   returns a one-cycle response to the granted port.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   pX_req_valid/we/addr/wdata
//                           request from port X, held until pX_req_ready
//   pX_req_ready            accept pulse; fields are captured this cycle
//   pX_rsp_valid/rdata/err  one-cycle response (err = watchdog abort)
//   mem_read_req/mem_write_req
//                           single-cycle strobes to the controller
//   mem_address/mem_write_data
//                           latched request, stable from ISSUE through WAIT
//   mem_read_data, mem_ready
//                           controller return data and completion pulse
//   busy                    high whenever a transaction is in progress
module sram_arbiter #(
  parameter int unsigned ADDR_W         = 15,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              p0_req_valid,
  input  logic              p0_req_we,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  output logic              p0_req_ready,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rsp_rdata,
  output logic              p0_rsp_err,

  input  logic              p1_req_valid,
  input  logic              p1_req_we,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  output logic              p1_req_ready,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rsp_rdata,
  output logic              p1_rsp_err,

  output logic              mem_read_req,
  output logic              mem_write_req,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_ready,

  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  // Last watchdog count value at which WAIT gives up.
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic              last_grant;
  logic              port_q;
  logic              we_q;
  logic [7:0]        wd_cnt;
  logic [DATA_W-1:0] rdata_q;

  logic              grant_valid;
  logic              grant_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              finish;
  logic [DATA_W-1:0] rsp_rdata_nx;
  logic              rsp_err_nx;

  // Arbitration. The accept pulse must coincide with the cycle in which the
  // request fields are captured, so ready is decoded from state and the
  // incoming valids rather than registered.
  always_comb begin
    grant_valid = 1'b0;
    grant_port  = 1'b0;
    if (state == S_IDLE) begin
      if (p0_req_valid && p1_req_valid) begin
        grant_valid = 1'b1;
        grant_port  = ~last_grant;
      end else if (p0_req_valid) begin
        grant_valid = 1'b1;
        grant_port  = 1'b0;
      end else if (p1_req_valid) begin
        grant_valid = 1'b1;
        grant_port  = 1'b1;
      end
    end
  end

  always_comb begin
    p0_req_ready = grant_valid & ~grant_port;
    p1_req_ready = grant_valid &  grant_port;
  end

  always_comb begin
    sel_we    = grant_port ? p1_req_we    : p0_req_we;
    sel_addr  = grant_port ? p1_req_addr  : p0_req_addr;
    sel_wdata = grant_port ? p1_req_wdata : p0_req_wdata;
  end

  // WAIT exit: completion takes priority over a same-cycle watchdog expiry.
  // Writes keep the previously returned read data; an abort returns zero.
  always_comb begin
    finish       = (state == S_WAIT) && (mem_ready || (wd_cnt == WD_LAST));
    rsp_err_nx   = ~mem_ready;
    rsp_rdata_nx = '0;
    if (mem_ready) begin
      rsp_rdata_nx = we_q ? rdata_q : mem_read_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      last_grant     <= 1'b1;
      port_q         <= 1'b0;
      we_q           <= 1'b0;
      wd_cnt         <= '0;
      rdata_q        <= '0;
      mem_read_req   <= 1'b0;
      mem_write_req  <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      p0_rsp_valid   <= 1'b0;
      p0_rsp_rdata   <= '0;
      p0_rsp_err     <= 1'b0;
      p1_rsp_valid   <= 1'b0;
      p1_rsp_rdata   <= '0;
      p1_rsp_err     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      // Strobes and responses are single-cycle pulses.
      mem_read_req  <= 1'b0;
      mem_write_req <= 1'b0;
      p0_rsp_valid  <= 1'b0;
      p0_rsp_rdata  <= '0;
      p0_rsp_err    <= 1'b0;
      p1_rsp_valid  <= 1'b0;
      p1_rsp_rdata  <= '0;
      p1_rsp_err    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            port_q         <= grant_port;
            last_grant     <= grant_port;
            we_q           <= sel_we;
            mem_address    <= sel_addr;
            mem_write_data <= sel_wdata;
            mem_read_req   <= ~sel_we;
            mem_write_req  <= sel_we;
            busy           <= 1'b1;
            state          <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          wd_cnt <= '0;
          state  <= S_WAIT;
        end

        S_WAIT: begin
          if (finish) begin
            rdata_q      <= rsp_rdata_nx;
            p0_rsp_valid <= ~port_q;
            p0_rsp_rdata <= port_q ? '0 : rsp_rdata_nx;
            p0_rsp_err   <= ~port_q & rsp_err_nx;
            p1_rsp_valid <= port_q;
            p1_rsp_rdata <= port_q ? rsp_rdata_nx : '0;
            p1_rsp_err   <= port_q & rsp_err_nx;
            state        <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end

        S_RESP: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
module tb_sram_arbiter;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p0_req_valid, p0_req_we, p0_req_ready, p0_rsp_valid, p0_rsp_err;
  logic [AW-1:0] p0_req_addr;
  logic [DW-1:0] p0_req_wdata, p0_rsp_rdata;
  logic          p1_req_valid, p1_req_we, p1_req_ready, p1_rsp_valid, p1_rsp_err;
  logic [AW-1:0] p1_req_addr;
  logic [DW-1:0] p1_req_wdata, p1_rsp_rdata;
  logic          mem_read_req, mem_write_req, mem_ready, busy;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data, mem_read_data;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_we(p0_req_we), .p0_req_addr(p0_req_addr),
    .p0_req_wdata(p0_req_wdata), .p0_req_ready(p0_req_ready), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_we(p1_req_we), .p1_req_addr(p1_req_addr),
    .p1_req_wdata(p1_req_wdata), .p1_req_ready(p1_req_ready), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .mem_ready(mem_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  req_t pq0[$];
  req_t pq1[$];

  // Latency of the n-th controller operation (0 = never completes); the
  // reference and the controller stand-in index it in accept/strobe order.
  int lat_arr[$];
  int acc_idx = 0;
  int str_idx = 0;

  function automatic int get_lat(input int i);
    return (i < lat_arr.size()) ? lat_arr[i] : 1;
  endfunction

  // Controller stand-in memory and reference memory (untouched words hold a
  // fixed pattern).
  logic [DW-1:0] cmem[int];
  logic [DW-1:0] rmem[int];

  function automatic logic [DW-1:0] mem_init(input int a);
    return 16'(a * 40503) ^ 16'h5A3C;
  endfunction
  function automatic logic [DW-1:0] c_rd(input int a);
    return cmem.exists(a) ? cmem[a] : mem_init(a);
  endfunction
  function automatic logic [DW-1:0] r_rd(input int a);
    return rmem.exists(a) ? rmem[a] : mem_init(a);
  endfunction

  int   ctl_cnt = -1;
  int   ctl_addr = 0;
  logic force_ready = 1'b0;

  // Reference: a transaction accepted at cycle T strobes at T+1 and responds
  // at T+2+min(latency, TO); the next accept is possible the cycle after.
  bit            m_active;
  int            m_T, m_R;
  logic          m_port, m_we, m_err, m_last_grant;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata, m_last_rdata;

  int            cyc = 0;
  int            acc_cyc, rsp_cyc;
  bit            rsp_seen;
  logic          rsp_port, rsp_err;
  logic [DW-1:0] rsp_rdata;
  int            grant_log[$];
  int            rsp_cnt0, rsp_cnt1;

  task automatic model_reset();
    m_active     = 0;
    m_last_grant = 1'b1;
    m_last_rdata = '0;
    ctl_cnt      = -1;
    str_idx      = acc_idx;
  endtask

  function automatic logic [63:0] out_vec();
    return {23'd0, p0_req_ready, p1_req_ready, p0_rsp_valid, p0_rsp_err, p0_rsp_rdata,
            p1_rsp_valid, p1_rsp_err, p1_rsp_rdata, mem_read_req, mem_write_req, busy};
  endfunction

  task automatic cycle();
    logic v0, v1, g;
    logic e_rdy0, e_rdy1, e_rv0, e_er0, e_rv1, e_er1, e_rreq, e_wreq, e_busy;
    logic [DW-1:0] e_rd0, e_rd1;
    req_t r;
    int   k, eff;
    @(posedge clk);
    #1;
    cyc++;
    v0 = (pq0.size() > 0);
    v1 = (pq1.size() > 0);
    p0_req_valid = v0;
    p1_req_valid = v1;
    p0_req_we = 1'($urandom); p0_req_addr = 15'($urandom); p0_req_wdata = 16'($urandom);
    p1_req_we = 1'($urandom); p1_req_addr = 15'($urandom); p1_req_wdata = 16'($urandom);
    if (v0) begin p0_req_we = pq0[0].we; p0_req_addr = pq0[0].addr; p0_req_wdata = pq0[0].wdata; end
    if (v1) begin p1_req_we = pq1[0].we; p1_req_addr = pq1[0].addr; p1_req_wdata = pq1[0].wdata; end
    mem_ready     = 1'b0;
    mem_read_data = 16'($urandom);
    if (ctl_cnt > 0) begin
      ctl_cnt--;
      if (ctl_cnt == 0) begin
        mem_ready     = 1'b1;
        mem_read_data = c_rd(ctl_addr);
        ctl_cnt       = -1;
      end
    end
    if (force_ready) mem_ready = 1'b1;
    @(negedge clk);

    {e_rdy0, e_rdy1, e_rv0, e_er0, e_rv1, e_er1, e_rreq, e_wreq, e_busy} = '0;
    e_rd0 = '0;
    e_rd1 = '0;
    if (m_active) begin
      e_busy = 1'b1;
      if (cyc == m_T + 1) begin
        e_rreq = ~m_we;
        e_wreq = m_we;
      end
      if (cyc < m_R) begin
        check($sformatf("cycle %0d mem_address", cyc), 64'(mem_address), 64'(m_addr));
        check($sformatf("cycle %0d mem_write_data", cyc), 64'(mem_write_data), 64'(m_wdata));
      end
      if (cyc == m_R) begin
        if (m_port) begin e_rv1 = 1'b1; e_rd1 = m_rdata; e_er1 = m_err; end
        else        begin e_rv0 = 1'b1; e_rd0 = m_rdata; e_er0 = m_err; end
        m_active = 0;
      end
    end else if (v0 || v1) begin
      g = (v0 && v1) ? ~m_last_grant : ~v0;
      if (g) e_rdy1 = 1'b1; else e_rdy0 = 1'b1;
      m_last_grant = g;
      r = g ? pq1[0] : pq0[0];
      k = get_lat(acc_idx);
      acc_idx++;
      m_err    = (k == 0) || (k > int'(TO));
      eff      = m_err ? int'(TO) : k;
      m_T      = cyc;
      m_R      = cyc + 2 + eff;
      m_active = 1;
      m_port   = g;
      m_we     = r.we;
      m_addr   = r.addr;
      m_wdata  = r.wdata;
      if (m_err)      m_rdata = '0;
      else if (!r.we) m_rdata = r_rd(int'(r.addr));
      else            m_rdata = m_last_rdata;
      m_last_rdata = m_rdata;
      if (r.we) rmem[int'(r.addr)] = r.wdata;
    end
    check($sformatf("cycle %0d outputs", cyc), out_vec(),
          {23'd0, e_rdy0, e_rdy1, e_rv0, e_er0, e_rd0, e_rv1, e_er1, e_rd1, e_rreq, e_wreq, e_busy});

    if (p0_req_ready && v0) begin void'(pq0.pop_front()); grant_log.push_back(0); acc_cyc = cyc; end
    if (p1_req_ready && v1) begin void'(pq1.pop_front()); grant_log.push_back(1); acc_cyc = cyc; end
    if (mem_read_req || mem_write_req) begin
      k = get_lat(str_idx);
      str_idx++;
      ctl_addr = int'(mem_address);
      if (mem_write_req) cmem[int'(mem_address)] = mem_write_data;
      ctl_cnt = (k > 0) ? k : -1;
    end
    if (p0_rsp_valid) begin
      rsp_seen = 1; rsp_cyc = cyc; rsp_port = 1'b0; rsp_rdata = p0_rsp_rdata; rsp_err = p0_rsp_err; rsp_cnt0++;
    end
    if (p1_rsp_valid) begin
      rsp_seen = 1; rsp_cyc = cyc; rsp_port = 1'b1; rsp_rdata = p1_rsp_rdata; rsp_err = p1_rsp_err; rsp_cnt1++;
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, " outputs"}, out_vec(), 64'd0);
    check({name, " mem_address"}, 64'(mem_address), 64'd0);
    check({name, " mem_write_data"}, 64'(mem_write_data), 64'd0);
  endtask

  task automatic push_req(input logic port, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int lat);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata;
    if (port) pq1.push_back(r); else pq0.push_back(r);
    lat_arr.push_back(lat);
  endtask

  task automatic run_until_rsp(input string name, input int budget);
    int n;
    rsp_seen = 0;
    n = 0;
    while (!rsp_seen && n < budget) begin cycle(); n++; end
    check({name, " response seen"}, 64'(rsp_seen), 64'd1);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((pq0.size() > 0 || pq1.size() > 0 || m_active) && n < budget) begin cycle(); n++; end
    check({name, " drained"}, 64'(pq0.size() + pq1.size() + int'(m_active)), 64'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    pq0.delete();
    pq1.delete();
    model_reset();
  endtask

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
    int            delay;
    logic          err;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t tbl[7];
  logic [AW-1:0] pool[8];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 15'h1234, 16'hABCD, 3, 5,  1'b0, 16'h0000};
    tbl[1] = '{1'b0, 1'b0, 15'h1234, 16'h0000, 2, 4,  1'b0, 16'hABCD};
    tbl[2] = '{1'b1, 1'b1, 15'h0001, 16'h5555, 1, 3,  1'b0, 16'hABCD};
    tbl[3] = '{1'b1, 1'b0, 15'h0001, 16'h0000, 8, 10, 1'b0, 16'h5555};
    tbl[4] = '{1'b0, 1'b0, 15'h1234, 16'h0000, 0, 10, 1'b1, 16'h0000};
    tbl[5] = '{1'b1, 1'b1, 15'h7FFF, 16'hFFFF, 9, 10, 1'b1, 16'h0000};
    tbl[6] = '{1'b0, 1'b0, 15'h0001, 16'h0000, 1, 3,  1'b0, 16'h5555};

    rst_n = 1'b0;
    p0_req_valid = 0; p0_req_we = 0; p0_req_addr = '0; p0_req_wdata = '0;
    p1_req_valid = 0; p1_req_we = 0; p1_req_addr = '0; p1_req_wdata = '0;
    mem_ready = 0; mem_read_data = '0;

    apply_reset();

    // Directed single transactions.
    for (int i = 0; i < 7; i++) begin
      push_req(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].lat);
      acc_cyc = -1;
      run_until_rsp($sformatf("vec%0d", i), 40);
      check($sformatf("vec%0d latency", i), 64'(rsp_cyc - acc_cyc), 64'(tbl[i].delay));
      check($sformatf("vec%0d port", i), 64'(rsp_port), 64'(tbl[i].port));
      check($sformatf("vec%0d err", i), 64'(rsp_err), 64'(tbl[i].err));
      check($sformatf("vec%0d rdata", i), 64'(rsp_rdata), 64'(tbl[i].rdata));
    end

    // Continuous contention after reset: strict alternation starting at port 0.
    apply_reset();
    grant_log.delete();
    rsp_cnt0 = 0;
    rsp_cnt1 = 0;
    for (int i = 0; i < 3; i++) begin
      push_req(1'b0, 1'b0, 15'h0100 + 15'(i), 16'h0, int'($urandom_range(1, 3)));
      push_req(1'b1, 1'b1, 15'h0200 + 15'(i), 16'(i * 3 + 7), int'($urandom_range(1, 3)));
    end
    drain("contention", 200);
    check("contention grant count", 64'(grant_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check($sformatf("contention grant %0d", i), 64'(grant_log[i]), 64'(i % 2));
    check("contention p0 responses", 64'(rsp_cnt0), 64'd3);
    check("contention p1 responses", 64'(rsp_cnt1), 64'd3);

    // Reset two cycles into WAIT: outputs drop at once, nothing responds.
    push_req(1'b0, 1'b0, 15'h1234, 16'h0, 0);
    acc_cyc = -1;
    begin
      int n;
      n = 0;
      while (acc_cyc < 0 && n < 10) begin cycle(); n++; end
    end
    check("midreset accepted", 64'(acc_cyc >= 0), 64'd1);
    cycle();
    cycle();
    cycle();
    rsp_seen = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset async");
    repeat (3) begin
      @(negedge clk);
      check("midreset held outputs", out_vec(), 64'd0);
    end
    rst_n = 1'b1;
    pq0.delete();
    pq1.delete();
    model_reset();
    push_req(1'b1, 1'b1, 15'h0042, 16'hBEEF, 2);
    run_until_rsp("post-reset p1", 40);
    check("post-reset port", 64'(rsp_port), 64'd1);
    check("post-reset err", 64'(rsp_err), 64'd0);

    // Spurious completion while idle must be ignored.
    rsp_seen = 0;
    force_ready = 1'b1;
    cycle();
    force_ready = 1'b0;
    cycle();
    check("spurious busy", 64'(busy), 64'd0);
    check("spurious no response", 64'(rsp_seen), 64'd0);
    push_req(1'b0, 1'b0, 15'h0042, 16'h0, 1);
    run_until_rsp("after spurious", 40);
    check("after spurious rdata", 64'(rsp_rdata), 64'hBEEF);

    // Randomized traffic against the reference.
    for (int i = 0; i < 8; i++) pool[i] = 15'($urandom);
    for (int c = 0; c < 600; c++) begin
      if (pq0.size() < 2 && $urandom_range(0, 2) == 0) begin
        int l;
        l = int'($urandom_range(0, 11));
        push_req(1'b0, 1'($urandom), pool[$urandom_range(0, 7)], 16'($urandom), (l == 11) ? 1 : l);
      end
      if (pq1.size() < 2 && $urandom_range(0, 2) == 0) begin
        int l;
        l = int'($urandom_range(0, 11));
        push_req(1'b1, 1'($urandom), pool[$urandom_range(0, 7)], 16'($urandom), (l == 11) ? 1 : l);
      end
      cycle();
    end
    drain("random", 300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
